key_debounce_array: RTL and testbench
=====================================

KEY_DEBOUNCE_ARRAY -- requirements
Module: key_debounce_array

Interface
REQ-001 SHALL provide parameter N_KEYS, default 4, number of independent key channels (1..32).
REQ-002 SHALL provide parameter DEBOUNCE_CYCLES, default 8, stable-clock count required to accept a press or release (>=2).
REQ-003 SHALL provide parameter LONG_CYCLES, default 32, clock count in debounced-down state before long-press pulse (>DEBOUNCE_CYCLES).
REQ-004 SHALL provide parameter ACTIVE_LOW, default 1, 1 = raw key reads 0 when pressed, 0 = reads 1 when pressed.
REQ-005 SHALL provide clk  input  1  system clock, all state on rising edge.
REQ-006 SHALL provide rst_n  input  1  reset, asynchronous, active-high.
REQ-007 SHALL provide enable  input  1  global enable; low forces all channels idle.
REQ-008 SHALL provide key_raw  input  N_KEYS  asynchronous raw key pins, bit i = channel i.
REQ-009 SHALL provide press_pulse  output  N_KEYS  one-cycle pulse per accepted press.
REQ-010 SHALL provide release_pulse  output  N_KEYS  one-cycle pulse per accepted release.
REQ-011 SHALL provide long_pulse  output  N_KEYS  one-cycle pulse when a press is held LONG_CYCLES.
REQ-012 SHALL provide key_level  output  N_KEYS  debounced pressed level (1 = pressed).
REQ-013 SHALL provide any_pressed  output  1  OR of key_level.

Function
REQ-014 Each channel SHALL pass key_raw through a 3-flop synchroniser s1->s2->s3, normalised so 1 = pressed (inverted when ACTIVE_LOW=1).
REQ-015 Press edge SHALL be s2 & !s3; release edge SHALL be !s2 & s3 (normalised).
REQ-016 Each channel SHALL run an independent FSM: IDLE, FILT_DN, DOWN, FILT_UP, with one counter of width clog2(LONG_CYCLES)+1.
REQ-017 IDLE: press edge -> FILT_DN, counter cleared to 0; otherwise stay.
REQ-018 FILT_DN: counter increments each cycle; counter==DEBOUNCE_CYCLES-1 -> DOWN, press_pulse=1 next cycle, counter cleared, long_done cleared; else release edge -> IDLE, no pulse.
REQ-019 Terminal count SHALL take priority over an opposing edge arriving in the same cycle (both filter states).
REQ-020 DOWN: counter increments, saturating at LONG_CYCLES-1; counter==LONG_CYCLES-1 and long_done==0 -> long_pulse=1 for one cycle, long_done=1; release edge -> FILT_UP, counter cleared.
REQ-021 FILT_UP: counter==DEBOUNCE_CYCLES-1 -> IDLE, release_pulse=1 next cycle; else press edge -> DOWN, counter cleared, long_done retained (no second long_pulse for same press).
REQ-022 Press latency SHALL be exactly DEBOUNCE_CYCLES+3 rising edges from the first edge sampling the new stable raw level to press_pulse high; release latency identical.
REQ-023 key_level SHALL be 1 in DOWN and FILT_UP, 0 in IDLE and FILT_DN; registered, changes on the same edge as the corresponding pulse.
REQ-024 All pulse outputs SHALL be registered and high for exactly one cycle; no two of press/release/long on one channel SHALL be high together.
REQ-025 enable low SHALL, on the next edge, force every FSM to IDLE, clear counters and all outputs; synchronisers keep running so re-enable with a held key produces no press until a fresh press edge.
REQ-026 Unused/illegal FSM encodings SHALL recover to IDLE with outputs 0 on the next edge.

Reset
REQ-027 rst_n high SHALL asynchronously set s1/s2/s3 to the released level (1 when ACTIVE_LOW=1), FSMs to IDLE, counters and long_done to 0, all outputs to 0.
REQ-028 Reset SHALL not generate an edge on release: a key held through reset SHALL produce exactly one press_pulse after reset release (edge from released sync value).
REQ-029 Reset asserted mid-filter or mid-hold SHALL abort with no pulse emitted.

Verification
REQ-030 Defaults; key_raw[0] 1->0 held 20 cycles -> press_pulse[0] high exactly 11 edges after first sample, one cycle; key_level[0]=1; any_pressed=1.
REQ-031 key_raw[1] low 5 cycles then high (bounce) -> no press_pulse[1], key_level[1] stays 0, FSM back to IDLE.
REQ-032 key_raw[2] held low 60 cycles then high -> press_pulse, one long_pulse 32 cycles after press_pulse, release_pulse 11 edges after rising sample; no further long_pulse.
REQ-033 Channels 0 and 3 pressed same cycle -> press_pulse=4'b1001 on same edge; release only ch3 -> release_pulse=4'b1000, key_level=4'b0001.
REQ-034 In DOWN, key_raw[0] high 4 cycles then low again -> no release_pulse, key_level stays 1, no second long_pulse after 32 more cycles.
REQ-035 enable dropped during DOWN then raised with key held -> outputs 0 next edge; no press_pulse until key released and re-pressed.

Source files
------------

// File: rtl/key_debounce_array_if.sv
// Control inputs and debounced event outputs of the key debouncer array.
interface key_debounce_array_if #(
    parameter int N_KEYS = 4
);
    logic              enable;
    logic [N_KEYS-1:0] key_raw;
    logic [N_KEYS-1:0] press_pulse;
    logic [N_KEYS-1:0] release_pulse;
    logic [N_KEYS-1:0] long_pulse;
    logic [N_KEYS-1:0] key_level;
    logic              any_pressed;

    modport master (
        output enable, key_raw,
        input  press_pulse, release_pulse, long_pulse, key_level, any_pressed
    );

    modport slave (
        input  enable, key_raw,
        output press_pulse, release_pulse, long_pulse, key_level, any_pressed
    );
endinterface

// File: rtl/key_debounce_array.sv
// Per-key synchroniser + debounce FSM producing press/release/long-press pulses and a level.
// Press/release pulses land DEBOUNCE_CYCLES+3 edges after the raw change is first sampled; no backpressure.
module key_debounce_array #(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int LONG_CYCLES     = 32,
    parameter int ACTIVE_LOW      = 1
) (
    input logic                  clk,
    input logic                  rst_n,
    key_debounce_array_if.slave  bus
);
    localparam int CW = $clog2(LONG_CYCLES) + 1;
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [N_KEYS-1:0] INV   = (ACTIVE_LOW != 0) ? {N_KEYS{1'b1}} : {N_KEYS{1'b0}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILT_DN = 2'd1,
        DOWN    = 2'd2,
        FILT_UP = 2'd3
    } state_t;

    logic [N_KEYS-1:0] s1, s2, s3;
    logic [N_KEYS-1:0] n2, n3;
    logic [N_KEYS-1:0] press_edge, rel_edge;
    logic [N_KEYS-1:0] press_v, release_v, long_v, level_v;

    // Synchronisers hold raw pin polarity and idle at the released level, so
    // a key held through reset still shows a press edge once reset lifts.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            s1 <= INV;
            s2 <= INV;
            s3 <= INV;
        end else begin
            s1 <= bus.key_raw;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign n2         = s2 ^ INV;
    assign n3         = s3 ^ INV;
    assign press_edge = n2 & ~n3;
    assign rel_edge   = ~n2 & n3;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        state_t        state, state_nx;
        logic [CW-1:0] cnt, cnt_nx;
        logic          long_done, long_done_nx;
        logic          press_r, release_r, long_r, level_r;
        logic          press_nx, release_nx, long_nx, level_nx;

        always_ff @(posedge clk or posedge rst_n) begin
            if (rst_n) begin
                state     <= IDLE;
                cnt       <= '0;
                long_done <= 1'b0;
                press_r   <= 1'b0;
                release_r <= 1'b0;
                long_r    <= 1'b0;
                level_r   <= 1'b0;
            end else begin
                state     <= state_nx;
                cnt       <= cnt_nx;
                long_done <= long_done_nx;
                press_r   <= press_nx;
                release_r <= release_nx;
                long_r    <= long_nx;
                level_r   <= level_nx;
            end
        end

        always_comb begin
            state_nx     = state;
            cnt_nx       = cnt;
            long_done_nx = long_done;
            press_nx     = 1'b0;
            release_nx   = 1'b0;
            long_nx      = 1'b0;
            level_nx     = 1'b0;

            case (state)
                IDLE: begin
                    if (press_edge[i]) begin
                        state_nx = FILT_DN;
                        cnt_nx   = '0;
                    end
                end
                // Terminal count is tested first so it wins over a same-cycle release edge.
                FILT_DN: begin
                    if (cnt == DEB_LAST) begin
                        state_nx     = DOWN;
                        cnt_nx       = '0;
                        long_done_nx = 1'b0;
                        press_nx     = 1'b1;
                    end else if (rel_edge[i]) begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + CNT_ONE;
                    end
                end
                DOWN: begin
                    if (cnt == LONG_LAST && !long_done) begin
                        long_nx      = 1'b1;
                        long_done_nx = 1'b1;
                    end
                    if (rel_edge[i]) begin
                        state_nx = FILT_UP;
                        cnt_nx   = '0;
                    end else if (cnt != LONG_LAST) begin
                        cnt_nx = cnt + CNT_ONE;
                    end
                end
                // A bounce back to pressed keeps long_done so one hold never reports long twice.
                FILT_UP: begin
                    if (cnt == DEB_LAST) begin
                        state_nx   = IDLE;
                        cnt_nx     = '0;
                        release_nx = 1'b1;
                    end else if (press_edge[i]) begin
                        state_nx = DOWN;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + CNT_ONE;
                    end
                end
                default: begin
                    state_nx     = IDLE;
                    cnt_nx       = '0;
                    long_done_nx = 1'b0;
                end
            endcase

            if (!bus.enable) begin
                state_nx     = IDLE;
                cnt_nx       = '0;
                long_done_nx = 1'b0;
                press_nx     = 1'b0;
                release_nx   = 1'b0;
                long_nx      = 1'b0;
            end

            level_nx = (state_nx == DOWN) || (state_nx == FILT_UP);
        end

        assign press_v[i]   = press_r;
        assign release_v[i] = release_r;
        assign long_v[i]    = long_r;
        assign level_v[i]   = level_r;
    end

    assign bus.press_pulse   = press_v;
    assign bus.release_pulse = release_v;
    assign bus.long_pulse    = long_v;
    assign bus.key_level     = level_v;
    assign bus.any_pressed   = |level_v;
endmodule

// File: tb/tb_key_debounce_array.sv
// Directed table-driven bench for key_debounce_array at default parameters.
module tb_key_debounce_array;
    logic clk = 1'b0;
    logic rst_n;

    key_debounce_array_if #(.N_KEYS(4)) bus ();

    key_debounce_array #(
        .N_KEYS(4),
        .DEBOUNCE_CYCLES(8),
        .LONG_CYCLES(32),
        .ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [3:0] raw;
        int         cyc;
        logic [3:0] prs;
        logic [3:0] rel;
        logic [3:0] lng;
        logic [3:0] lvl;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic add(input logic en, input logic [3:0] raw, input int cyc,
                       input logic [3:0] prs, input logic [3:0] rel,
                       input logic [3:0] lng, input logic [3:0] lvl);
        vec_t v;
        v.en = en; v.raw = raw; v.cyc = cyc;
        v.prs = prs; v.rel = rel; v.lng = lng; v.lvl = lvl;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [3:0] prs, input logic [3:0] rel,
                             input logic [3:0] lng, input logic [3:0] lvl);
        check({tag, ".press"},   32'(bus.press_pulse),   32'(prs));
        check({tag, ".release"}, 32'(bus.release_pulse), 32'(rel));
        check({tag, ".long"},    32'(bus.long_pulse),    32'(lng));
        check({tag, ".level"},   32'(bus.key_level),     32'(lvl));
        check({tag, ".any"},     32'(bus.any_pressed),   32'(|lvl));
    endtask

    initial begin
        logic [3:0] stray;

        rst_n = 1'b1;
        bus.enable = 1'b1;
        bus.key_raw = 4'b1111;
        repeat (3) tick();
        check_all("reset", 4'h0, 4'h0, 4'h0, 4'h0);
        rst_n = 1'b0;
        tick();

        //   en  raw      cyc prs      rel      lng      lvl
        // single press on ch0, 20-cycle hold, release
        add(1, 4'b1110, 10, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(1, 4'b1110,  1, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        add(1, 4'b1110,  1, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        add(1, 4'b1110,  8, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        add(1, 4'b1111, 10, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        add(1, 4'b1111,  1, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        add(1, 4'b1111,  1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        // ch1 bounce shorter than the filter
        add(1, 4'b1101,  5, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(1, 4'b1111, 12, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        // ch2 long hold: long 32 after press, release 11 after rise
        add(1, 4'b1011, 10, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(1, 4'b1011,  1, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
        add(1, 4'b1011, 31, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
        add(1, 4'b1011,  1, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
        add(1, 4'b1011, 17, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
        add(1, 4'b1111, 10, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
        add(1, 4'b1111,  1, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
        add(1, 4'b1111, 40, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        // ch0 and ch3 together, release ch3 only, then ch0
        add(1, 4'b0110, 10, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(1, 4'b0110,  1, 4'b1001, 4'b0000, 4'b0000, 4'b1001);
        add(1, 4'b0110,  5, 4'b0000, 4'b0000, 4'b0000, 4'b1001);
        add(1, 4'b1110, 10, 4'b0000, 4'b0000, 4'b0000, 4'b1001);
        add(1, 4'b1110,  1, 4'b0000, 4'b1000, 4'b0000, 4'b0001);
        add(1, 4'b1111, 11, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        // ch0 long, then a 4-cycle release bounce, no second long
        add(1, 4'b1110, 11, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        add(1, 4'b1110, 32, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
        add(1, 4'b1111,  4, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        add(1, 4'b1110, 45, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        add(1, 4'b1111, 11, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        // enable drop during hold on ch1; no press until fresh press edge
        add(1, 4'b1101, 11, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
        add(1, 4'b1101,  3, 4'b0000, 4'b0000, 4'b0000, 4'b0010);
        add(0, 4'b1101,  1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(0, 4'b1101,  5, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(1, 4'b1101, 20, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(1, 4'b1111, 12, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(1, 4'b1101, 11, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
        add(1, 4'b1111, 11, 4'b0000, 4'b0010, 4'b0000, 4'b0000);

        for (int v = 0; v < tbl.size(); v++) begin
            bus.enable  = tbl[v].en;
            bus.key_raw = tbl[v].raw;
            stray = 4'b0000;
            for (int c = 0; c < tbl[v].cyc; c++) begin
                tick();
                if (c < tbl[v].cyc - 1)
                    stray |= bus.press_pulse | bus.release_pulse | bus.long_pulse;
            end
            check($sformatf("vec%0d.stray", v), 32'(stray), 32'h0);
            check_all($sformatf("vec%0d", v), tbl[v].prs, tbl[v].rel, tbl[v].lng, tbl[v].lvl);
        end

        // Reset mid-filter with ch0 held: aborted, then exactly one press after reset lifts.
        bus.enable  = 1'b1;
        bus.key_raw = 4'b1110;
        repeat (5) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        check_all("rst_filt", 4'h0, 4'h0, 4'h0, 4'h0);
        rst_n = 1'b0;
        stray = 4'b0000;
        for (int c = 0; c < 10; c++) begin
            tick();
            stray |= bus.press_pulse | bus.release_pulse | bus.long_pulse;
        end
        check("held_rst.early", 32'(stray), 32'h0);
        tick();
        check_all("held_rst.press", 4'b0001, 4'h0, 4'h0, 4'b0001);
        stray = 4'b0000;
        for (int c = 0; c < 15; c++) begin
            tick();
            stray |= bus.press_pulse;
        end
        check("held_rst.single", 32'(stray), 32'h0);

        // Reset mid-hold clears asynchronously and nothing follows once released.
        #2;
        rst_n = 1'b1;
        #1;
        check("async_rst.level", 32'(bus.key_level), 32'h0);
        check("async_rst.any", 32'(bus.any_pressed), 32'h0);
        bus.key_raw = 4'b1111;
        repeat (2) tick();
        rst_n = 1'b0;
        stray = 4'b0000;
        for (int c = 0; c < 20; c++) begin
            tick();
            stray |= bus.press_pulse | bus.release_pulse | bus.long_pulse;
        end
        check("rst_hold.stray", 32'(stray), 32'h0);
        check_all("rst_hold.end", 4'h0, 4'h0, 4'h0, 4'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
